// File: rtl/ball_ctrl_pkg.sv
// Shared geometry, speeds and types for the pong ball engine.
// Sprites carry inclusive bounds; velocities are sign+magnitude.
package ball_ctrl_pkg;

    localparam int SCREEN_H_RES     = 640;
    localparam int SCREEN_V_RES     = 480;
    localparam int SCREEN_BORDER    = 10;
    localparam int BALL_SIDE        = 10;
    localparam int PADDLE_HEIGHT    = 50;
    localparam int PADDLE_CENTER    = PADDLE_HEIGHT / 2;

    localparam int X_POS_W          = 10;
    localparam int Y_POS_W          = 9;
    localparam int SPEED_W          = 4;

    localparam int DEFLECT_SPEED_X  = 4;
    localparam int DEFLECT_SPEED_Y  = 1;
    localparam int SIDE_HIT_SPEED_Y = 5;

    localparam int BALL_START_X     = (SCREEN_H_RES - BALL_SIDE) / 2;
    localparam int BALL_START_Y     = (SCREEN_V_RES - BALL_SIDE) / 2;

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    typedef enum logic [1:0] {SERVE, MOVE, SCORED} ball_state_t;

    // dir is 1 for left (x axis) or up (y axis)
    typedef struct packed {
        logic               dir;
        logic [SPEED_W-2:0] mag;
    } ball_vel_t;

endpackage

// File: rtl/ball_paddle_hit.sv
// Combinational paddle collision test: reports a hit, the x the ball snaps to,
// and the new vertical velocity derived from where on the paddle it struck.
module ball_paddle_hit
    import ball_ctrl_pkg::*;
#(
    parameter bit RIGHT_SIDE = 1'b0
) (
    input  logic [X_POS_W-1:0] ball_x,
    input  logic [Y_POS_W-1:0] ball_y,
    input  logic [X_POS_W:0]   next_x,
    input  logic               dir_left,
    input  sprite_t            paddle,
    output logic               hit,
    output logic [X_POS_W-1:0] hit_x,
    output ball_vel_t          vy
);

    logic [X_POS_W:0] ball_right;
    logic [X_POS_W:0] next_right;
    logic [Y_POS_W:0] ball_bottom;
    logic [Y_POS_W:0] ball_mid;
    logic [Y_POS_W:0] off;
    logic             y_overlap;
    logic             hit_left;
    logic             hit_right;

    assign ball_right  = {1'b0, ball_x} + (X_POS_W+1)'(BALL_SIDE - 1);
    assign next_right  = next_x + (X_POS_W+1)'(BALL_SIDE - 1);
    assign ball_bottom = {1'b0, ball_y} + (Y_POS_W+1)'(BALL_SIDE - 1);
    assign ball_mid    = {1'b0, ball_y} + (Y_POS_W+1)'(BALL_SIDE / 2);

    assign y_overlap = (ball_y <= paddle.bottom) && (ball_bottom >= {1'b0, paddle.y_pos});

    // A left-moving ball may have wrapped below zero; the top bit of next_x flags that
    assign hit_left  = dir_left && y_overlap && (ball_x > paddle.right)
                     && (next_x[X_POS_W] || (next_x[X_POS_W-1:0] <= paddle.right));
    assign hit_right = !dir_left && y_overlap && (ball_right < {1'b0, paddle.x_pos})
                     && (next_right >= {1'b0, paddle.x_pos});

    assign hit   = RIGHT_SIDE ? hit_right : hit_left;
    assign hit_x = RIGHT_SIDE ? (paddle.x_pos - X_POS_W'(BALL_SIDE))
                              : (paddle.right + X_POS_W'(1));

    // NOTE: every branch assigns off, so no latch is inferred
    always_comb begin
        off = ball_mid - {1'b0, paddle.y_pos};
        if (ball_mid < {1'b0, paddle.y_pos}) begin
            off = '0;
        end else if (off > (Y_POS_W+1)'(PADDLE_HEIGHT - 1)) begin
            off = (Y_POS_W+1)'(PADDLE_HEIGHT - 1);
        end
    end

    assign vy.mag = ((off < (Y_POS_W+1)'(PADDLE_HEIGHT / 4))
                  || (off >= (Y_POS_W+1)'(3 * PADDLE_HEIGHT / 4)))
                  ? (SPEED_W-1)'(SIDE_HIT_SPEED_Y) : (SPEED_W-1)'(DEFLECT_SPEED_Y);
    assign vy.dir = off < (Y_POS_W+1)'(PADDLE_CENTER);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: serves from centre, moves once per frame, bounces off the
// borders and paddles, and pulses a score when a paddle misses.
module ball_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int SERVE_FRAMES = 60
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    frame_tick_i,
    input  logic    pause_i,
    input  sprite_t player_i,
    input  sprite_t enemy_i,
    output sprite_t ball_o,
    output logic    ball_dir_left_o,
    output logic    score_player_o,
    output logic    score_enemy_o
);

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    ball_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_POS_W-1:0] x_q, x_d;
    logic [Y_POS_W-1:0] y_q, y_d;
    logic               left_q, left_d;
    ball_vel_t          vy_q, vy_d;
    logic               score_player_q, score_player_d;
    logic               score_enemy_q, score_enemy_d;

    logic               update;
    logic [X_POS_W:0]   nx;
    logic [Y_POS_W:0]   ny;
    logic               ny_top, ny_bot, miss;
    logic               hit_l, hit_r;
    logic [X_POS_W-1:0] hit_l_x, hit_r_x;
    ball_vel_t          hit_l_vy, hit_r_vy;

    assign update = frame_tick_i && !pause_i;

    // One bit wider than the position so a step past zero is visible
    assign nx = left_q ? ({1'b0, x_q} - (X_POS_W+1)'(DEFLECT_SPEED_X))
                       : ({1'b0, x_q} + (X_POS_W+1)'(DEFLECT_SPEED_X));
    assign ny = vy_q.dir ? ({1'b0, y_q} - (Y_POS_W+1)'(vy_q.mag))
                         : ({1'b0, y_q} + (Y_POS_W+1)'(vy_q.mag));

    assign ny_top = (vy_q.dir && ny[Y_POS_W]) || (ny < (Y_POS_W+1)'(SCREEN_BORDER));
    assign ny_bot = (ny + (Y_POS_W+1)'(BALL_SIDE)) > (Y_POS_W+1)'(SCREEN_V_RES - SCREEN_BORDER);
    assign miss   = !hit_l && !hit_r
                  && ((left_q && nx[X_POS_W])
                   || (!left_q && ((nx + (X_POS_W+1)'(BALL_SIDE)) > (X_POS_W+1)'(SCREEN_H_RES))));

    ball_paddle_hit #(.RIGHT_SIDE(1'b0)) u_hit_player (
        .ball_x   (x_q),
        .ball_y   (y_q),
        .next_x   (nx),
        .dir_left (left_q),
        .paddle   (player_i),
        .hit      (hit_l),
        .hit_x    (hit_l_x),
        .vy       (hit_l_vy)
    );

    ball_paddle_hit #(.RIGHT_SIDE(1'b1)) u_hit_enemy (
        .ball_x   (x_q),
        .ball_y   (y_q),
        .next_x   (nx),
        .dir_left (left_q),
        .paddle   (enemy_i),
        .hit      (hit_r),
        .hit_x    (hit_r_x),
        .vy       (hit_r_vy)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        x_d            = x_q;
        y_d            = y_q;
        left_d         = left_q;
        vy_d           = vy_q;
        score_player_d = 1'b0;
        score_enemy_d  = 1'b0;
        if (update) begin
            case (state_q)
                SERVE: begin
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) state_d = MOVE;
                    else                                   cnt_d   = cnt_q + 1'b1;
                end
                MOVE: begin
                    if (miss) begin
                        // Ball freezes; serve direction is inherited from left_q
                        state_d        = SCORED;
                        score_enemy_d  = left_q;
                        score_player_d = !left_q;
                    end else begin
                        if (hit_l) begin
                            x_d    = hit_l_x;
                            left_d = 1'b0;
                            vy_d   = hit_l_vy;
                        end else if (hit_r) begin
                            x_d    = hit_r_x;
                            left_d = 1'b1;
                            vy_d   = hit_r_vy;
                        end else begin
                            x_d = nx[X_POS_W-1:0];
                        end
                        if (ny_top) begin
                            y_d      = Y_POS_W'(SCREEN_BORDER);
                            vy_d.dir = 1'b0;
                        end else if (ny_bot) begin
                            y_d      = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER - BALL_SIDE);
                            vy_d.dir = 1'b1;
                        end else begin
                            y_d = ny[Y_POS_W-1:0];
                        end
                    end
                end
                SCORED: begin
                    state_d  = SERVE;
                    cnt_d    = '0;
                    x_d      = X_POS_W'(BALL_START_X);
                    y_d      = Y_POS_W'(BALL_START_Y);
                    vy_d.dir = 1'b0;
                    vy_d.mag = (SPEED_W-1)'(DEFLECT_SPEED_Y);
                end
                default: state_d = SERVE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SERVE;
            cnt_q          <= '0;
            x_q            <= X_POS_W'(BALL_START_X);
            y_q            <= Y_POS_W'(BALL_START_Y);
            left_q         <= 1'b1;
            vy_q.dir       <= 1'b0;
            vy_q.mag       <= (SPEED_W-1)'(DEFLECT_SPEED_Y);
            score_player_q <= 1'b0;
            score_enemy_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            left_q         <= left_d;
            vy_q           <= vy_d;
            score_player_q <= score_player_d;
            score_enemy_q  <= score_enemy_d;
        end
    end

    assign ball_o.x_pos    = x_q;
    assign ball_o.y_pos    = y_q;
    assign ball_o.right    = x_q + X_POS_W'(BALL_SIDE - 1);
    assign ball_o.bottom   = y_q + Y_POS_W'(BALL_SIDE - 1);
    assign ball_dir_left_o = left_q;
    assign score_player_o  = score_player_q;
    assign score_enemy_o   = score_enemy_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: a literal rally table, hand-written corner sequences,
// then random paddles/pauses checked against an integer reference model.
module tb_ball_ctrl;
    import ball_ctrl_pkg::*;

    localparam int PL_X = 20;
    localparam int EN_X = 610;
    localparam int PH_SERVE = 0, PH_MOVE = 1, PH_SCORED = 2;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    frame_tick_i;
    logic    pause_i;
    sprite_t player, enemy, ball;
    logic    dir_left, score_p, score_e;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state, plain integers
    int m_x, m_y, m_vy, m_cnt, m_phase;
    bit m_left, m_up, m_sp, m_se;

    always #5 clk = ~clk;

    ball_ctrl #(.SERVE_FRAMES(60)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick_i    (frame_tick_i),
        .pause_i         (pause_i),
        .player_i        (player),
        .enemy_i         (enemy),
        .ball_o          (ball),
        .ball_dir_left_o (dir_left),
        .score_player_o  (score_p),
        .score_enemy_o   (score_e)
    );

    typedef struct {
        int ticks;
        int py;
        int ey;
        int exp_x;
        int exp_y;
        bit exp_left;
    } vec_t;

    function automatic sprite_t paddle(input int x, input int y);
        sprite_t s;
        s.x_pos  = X_POS_W'(x);
        s.y_pos  = Y_POS_W'(y);
        s.right  = X_POS_W'(x + 9);
        s.bottom = Y_POS_W'(y + 49);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 315; m_y = 235; m_vy = 1; m_up = 0; m_left = 1;
        m_cnt = 0; m_phase = PH_SERVE; m_sp = 0; m_se = 0;
    endtask

    // Game rules in the 640x480 geometry, player paddle at x 20..29, enemy at 610..619
    task automatic model_tick(input int py, input int ey);
        int nx, ny, off;
        bit hl, hr;
        m_sp = 0;
        m_se = 0;
        case (m_phase)
            PH_SERVE: if (m_cnt == 59) m_phase = PH_MOVE; else m_cnt++;
            PH_SCORED: begin
                m_x = 315; m_y = 235; m_vy = 1; m_up = 0; m_cnt = 0; m_phase = PH_SERVE;
            end
            default: begin
                nx = m_left ? m_x - 4 : m_x + 4;
                ny = m_up ? m_y - m_vy : m_y + m_vy;
                hl = m_left && m_x > PL_X + 9 && nx <= PL_X + 9 && m_y <= py + 49 && m_y + 9 >= py;
                hr = !m_left && m_x + 9 < EN_X && nx + 9 >= EN_X && m_y <= ey + 49 && m_y + 9 >= ey;
                if (!hl && !hr && (nx < 0 || nx + 10 > 640)) begin
                    m_se = m_left;
                    m_sp = !m_left;
                    m_phase = PH_SCORED;
                end else begin
                    if (hl || hr) begin
                        off = m_y + 5 - (hl ? py : ey);
                        if (off < 0) off = 0;
                        if (off > 49) off = 49;
                        m_vy = (off < 12 || off >= 37) ? 5 : 1;
                        m_up = off < 25;
                        m_left = hr;
                        m_x = hl ? PL_X + 10 : EN_X - 10;
                    end else begin
                        m_x = nx;
                    end
                    if (ny < 10) begin
                        m_y = 10; m_up = 0;
                    end else if (ny + 10 > 470) begin
                        m_y = 460; m_up = 1;
                    end else begin
                        m_y = ny;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".x"}, 32'(ball.x_pos), m_x);
        check({tag, ".y"}, 32'(ball.y_pos), m_y);
        check({tag, ".right"}, 32'(ball.right), m_x + 9);
        check({tag, ".bottom"}, 32'(ball.bottom), m_y + 9);
        check({tag, ".left"}, 32'(dir_left), 32'(m_left));
        check({tag, ".score_p"}, 32'(score_p), 32'(m_sp));
        check({tag, ".score_e"}, 32'(score_e), 32'(m_se));
    endtask

    task automatic do_tick(input bit pause, input int py, input int ey, input string tag);
        @(negedge clk);
        check({tag, ".pulse_clear"}, 32'({score_p, score_e}), 0);
        player       = paddle(PL_X, py);
        enemy        = paddle(EN_X, ey);
        pause_i      = pause;
        frame_tick_i = 1'b1;
        @(negedge clk);
        frame_tick_i = 1'b0;
        pause_i      = 1'b0;
        if (!pause) model_tick(py, ey);
        else begin m_sp = 0; m_se = 0; end
        compare_model(tag);
        // paddles are only sampled on update cycles, so scramble them in between
        player = paddle(PL_X, int'($urandom_range(0, 462)));
        enemy  = paddle(EN_X, int'($urandom_range(0, 462)));
    endtask

    task automatic check_ball(input string tag, input int x, input int y, input bit left);
        check({tag, ".x"}, 32'(ball.x_pos), x);
        check({tag, ".y"}, 32'(ball.y_pos), y);
        check({tag, ".left"}, 32'(dir_left), 32'(left));
    endtask

    function automatic int track(input int y);
        int p;
        p = y + 9 - int'($urandom_range(0, 58));
        if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 462));
        if (p < 0) p = 0;
        if (p > 462) p = 462;
        return p;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{59,   0,   0, 315, 235, 1};
        vecs[1]  = '{ 1,   0,   0, 315, 235, 1};
        vecs[2]  = '{ 1,   0,   0, 311, 236, 1};
        vecs[3]  = '{70, 286,   0,  31, 306, 1};
        vecs[4]  = '{ 1, 286,   0,  30, 307, 0};
        vecs[5]  = '{142, 286, 452, 598, 449, 0};
        vecs[6]  = '{ 1, 286, 452, 600, 450, 1};
        vecs[7]  = '{88, 286, 452, 248,  10, 1};
        vecs[8]  = '{ 1, 286, 452, 244,  10, 1};
        vecs[9]  = '{ 1, 286, 452, 240,  15, 1};
        vecs[10] = '{52, 400, 452,  32, 275, 1};
        vecs[11] = '{ 8, 400, 452,   0, 315, 1};

        rst_n = 1'b0; frame_tick_i = 1'b0; pause_i = 1'b0;
        player = paddle(PL_X, 0);
        enemy  = paddle(EN_X, 0);
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.right", 32'(ball.right), 324);
        check("reset.bottom", 32'(ball.bottom), 244);
        check("reset.score_p", 32'(score_p), 0);
        check("reset.score_e", 32'(score_e), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_ball("release", 315, 235, 1);

        for (int i = 0; i < 12; i++) begin
            for (int t = 0; t < vecs[i].ticks; t++) do_tick(1'b0, vecs[i].py, vecs[i].ey, $sformatf("vec%0d", i));
            check_ball($sformatf("vec%0d.end", i), vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_left);
        end

        // left-edge miss: one-cycle enemy score, ball frozen, then recentred serve
        do_tick(1'b0, 400, 452, "miss");
        check("miss.score_e", 32'(score_e), 1);
        check_ball("miss.frozen", 0, 315, 1);
        @(negedge clk);
        check("miss.pulse_len", 32'(score_e), 0);
        do_tick(1'b0, 400, 452, "scored");
        check_ball("serve", 315, 235, 1);

        // back into play, then paused ticks must hold everything
        for (int t = 0; t < 61; t++) do_tick(1'b0, 0, 0, "reserve");
        check_ball("reserve.move", 311, 236, 1);
        for (int t = 0; t < 10; t++) do_tick(1'b1, 0, 0, "pause");
        check_ball("pause.hold", 311, 236, 1);
        do_tick(1'b0, 0, 0, "unpause");
        check_ball("unpause", 307, 237, 1);

        // asynchronous reset mid-frame recentres before any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_ball("async_rst", 315, 235, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(1'b0, 0, 0, "post_rst");
        check_ball("post_rst.serve", 315, 235, 1);

        // randomized rallies against the model
        for (int n = 0; n < 2500; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_tick($urandom_range(0, 9) == 0, track(m_y), track(m_y), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
